// File: rtl/cnn_mac_pipe.sv
// Pipelined signed multiply-accumulate: input reg, MUL_STAGE product regs,
// per-group accumulator, then rescale/saturate into a handshaked output register.
module cnn_mac_pipe #(
  parameter int A_W       = 9,
  parameter int B_W       = 14,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 8,
  parameter int MUL_STAGE = 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  input  logic                    in_last,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_rdy,
  output logic                    dout_sat
);

  // Wide enough to hold both the group sum and the OUT_W clip limits.
  localparam int XW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  function automatic logic signed [ACC_W-1:0] rescale(input logic signed [ACC_W-1:0] s);
    return s >>> SHIFT;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] r);
    logic signed [XW-1:0] rx;
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    rx = {{(XW-ACC_W){r[ACC_W-1]}}, r};
    hi = (XW'(1) <<< (OUT_W-1)) - XW'(1);
    lo = -(XW'(1) <<< (OUT_W-1));
    if (rx > hi) return {1'b1, hi[OUT_W-1:0]};
    if (rx < lo) return {1'b1, lo[OUT_W-1:0]};
    return {1'b0, rx[OUT_W-1:0]};
  endfunction

  logic                        en;
  logic                        vld_p0;
  logic                        last_p0;
  logic signed [A_W-1:0]       a_p0;
  logic signed [B_W-1:0]       b_p0;
  logic signed [A_W+B_W-1:0]   mul;
  logic [MUL_STAGE-1:0]        vld_p1;
  logic [MUL_STAGE-1:0]        last_p1;
  logic signed [ACC_W-1:0]     prod_p1 [MUL_STAGE];
  logic signed [ACC_W-1:0]     acc;
  logic                        first;
  logic signed [ACC_W-1:0]     sum;
  logic                        vld_p2;
  logic signed [ACC_W-1:0]     gsum_p2;
  logic signed [ACC_W-1:0]     rsc;
  logic [OUT_W:0]              satv;

  // A held result with no taker freezes the whole pipe.
  assign en     = !(dout_vld && !dout_rdy);
  assign in_rdy = en;

  assign mul  = a_p0 * b_p0;
  assign sum  = (first ? '0 : acc) + prod_p1[MUL_STAGE-1];
  assign rsc  = rescale(gsum_p2);
  assign satv = saturate(rsc);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_p0   <= 1'b0;
      vld_p1   <= '0;
      vld_p2   <= 1'b0;
      acc      <= '0;
      first    <= 1'b1;
      dout     <= '0;
      dout_sat <= 1'b0;
      dout_vld <= 1'b0;
    end else if (en) begin
      // p0: input register
      vld_p0 <= in_vld;
      // p1: product registers
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < MUL_STAGE; i++) vld_p1[i] <= vld_p1[i-1];
      // p2: accumulate; only a group's final sum travels on
      vld_p2 <= vld_p1[MUL_STAGE-1] && last_p1[MUL_STAGE-1];
      if (vld_p1[MUL_STAGE-1]) begin
        if (last_p1[MUL_STAGE-1]) begin
          acc   <= '0;
          first <= 1'b1;
        end else begin
          acc   <= sum;
          first <= 1'b0;
        end
      end
      // output register: a new result wins over a drain in the same cycle
      if (vld_p2) begin
        dout     <= satv[OUT_W-1:0];
        dout_sat <= satv[OUT_W];
        dout_vld <= 1'b1;
      end else begin
        dout_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (en) begin
      a_p0       <= din0;
      b_p0       <= din1;
      last_p0    <= in_last;
      prod_p1[0] <= ACC_W'(mul);
      last_p1[0] <= last_p0;
      for (int i = 1; i < MUL_STAGE; i++) begin
        prod_p1[i] <= prod_p1[i-1];
        last_p1[i] <= last_p1[i-1];
      end
      gsum_p2 <= sum;
    end
  end

endmodule

// File: doc/cnn_mac_pipe.md
Name: cnn_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit; next generation of the combinational DSP48 multipliers used in the conv/fc datapaths.
- Consumes a stream of (din0, din1) term pairs, accumulates the products per group delimited by in_last, then rescales and saturates each group sum to OUT_W.
- Valid/ready handshake on both sides; maps to one DSP48 with pipeline registers.

Parameters:
- A_W, 9, signed width of din0 (activation)
- B_W, 14, signed width of din1 (weight)
- ACC_W, 32, signed accumulator width; must be >= A_W+B_W
- OUT_W, 16, signed output width
- SHIFT, 8, arithmetic right shift applied to group sum before saturation (fixed-point rescale); 0..ACC_W-1
- MUL_STAGE, 1, product pipeline registers; 1..3

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  synchronous active-high reset
- in_vld  in  1  term pair valid
- in_rdy  out  1  unit can accept a term this cycle
- din0  in  A_W  signed operand a
- din1  in  B_W  signed operand b
- in_last  in  1  term is the final one of its group
- dout  out  OUT_W  signed rescaled, saturated group sum
- dout_vld  out  1  dout holds a result
- dout_rdy  in  1  downstream accepts dout
- dout_sat  out  1  dout was clipped; qualified by dout_vld

Behaviour:
- Reset: dout=0, dout_vld=0, dout_sat=0, accumulator=0, all pipeline valid bits=0, group-start flag=1. in_rdy=1 in the first cycle after reset deasserts. Reset mid-group discards all in-flight terms and any partial sum.
- Global enable en = !(dout_vld && !dout_rdy). in_rdy = en. When en=0, every pipeline register, the accumulator and the output register hold their values.
- Transfer occurs when in_vld && in_rdy. Terms presented while in_rdy=0 are not consumed; the source must hold them.
- Pipeline:
  - Input register (1 cycle).
  - MUL_STAGE product registers: prod = signed(a)*signed(b), full A_W+B_W bits, sign-extended to ACC_W.
  - Accumulate/output stage:
    - sum = (first ? 0 : acc) + prod, wrapping modulo 2^ACC_W. No internal saturation; ACC_W is sized by the integrator.
    - If the term is not last: acc <= sum, first <= 0.
    - If last: acc <= 0, first <= 1, and the output register loads r = sum >>> SHIFT (arithmetic shift, floor rounding). dout = r clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; dout_sat = 1 iff clipped; dout_vld <= 1.
- Latency: last term accepted at edge t gives dout_vld=1 after edge t+MUL_STAGE+2 (default 3 cycles) when not stalled.
- Output register:
  - Cleared (dout_vld <= 0) on dout_vld && dout_rdy unless a new result loads in the same cycle.
  - Load and drain in the same cycle: new result wins, dout_vld stays 1.
  - dout/dout_sat remain stable while dout_vld=1 and dout_rdy=0.
- Throughput: one term per cycle. Back-to-back groups, including single-term groups, run with no bubbles.
- in_vld=0 cycles inside a group insert bubbles. Bubbles do not alter acc or first.

Test Plan:
- Single-term group: din0=3, din1=100, in_last=1, dout_rdy=1 -> exactly 3 cycles later dout=1 (300>>>8), dout_sat=0, dout_vld high for 1 cycle.
- 4-term group: din0=10, din1=256 each, last on 4th, dout_rdy=1 -> dout=40; follow immediately with single term (-1, 1, last) -> next-cycle result dout=-1 (floor), proving accumulator cleared and no bubble.
- Saturation: 16 terms din0=-256, din1=-8192 (sum 33554432) -> dout=32767, dout_sat=1. Same with din1=8191 sign-flipped (sum -33550336) -> dout=-32768, dout_sat=1.
- Backpressure: dout_rdy=0 while a result is pending and 5 more terms are offered -> in_rdy=0, dout stable, no terms lost. Raise dout_rdy -> subsequent group result is correct and arrives in order.
- Reset mid-group: 2 terms of a 4-term group, assert ap_rst 1 cycle, then a fresh group (2, 128, last) -> dout=1; no residue from the aborted group; dout_vld=0 during reset.
- Parameter sweep MUL_STAGE=3, SHIFT=0, OUT_W=32: random 1–64 term groups with in_vld and dout_rdy randomly deasserted -> latency 5, results bit-exact vs reference model.
